ptosda_sched: RTL

Round-robin scheduler that shares one `ptosda` parallel-to-serial SDA transmitter between several nibble producers. Each requester owns a small nibble FIFO. The scheduler picks a requester, presents one 4-bit nibble to the transmitter's `data` input, and waits for the transmitter's `ack` rising edge before advancing. It sits between the producer logic and `ptosda`, on the same `sclk` domain.

---
 rtl/ptosda_sched_pkg.sv | 26 ++
 rtl/nibble_fifo.sv | 69 ++++++
 rtl/ptosda_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ptosda_sched_pkg.sv
// Shared definitions for the ptosda nibble scheduler.
//   NIBBLE_W : width of one nibble handed to the ptosda transmitter
//   state_t  : scheduler FSM state, 2-bit encoding
//   rr_next  : round-robin successor of a requester index, wrapping at nreq
package ptosda_sched_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOAD = 2'd2,
    WAIT = 2'd3
  } state_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned nreq);
    logic [1:0] nxt;
    if ({30'd0, idx} + 32'd1 >= nreq) begin
      nxt = 2'd0;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Per-requester nibble FIFO.
//   sclk  : clock, rising edge
//   rst   : asynchronous active-low reset
//   push  : write wdata when not full (pushes while full are dropped)
//   wdata : nibble to write
//   pop   : advance read pointer when not empty
//   full  : DEPTH entries held
//   empty : no entries held
//   count : number of entries held
//   rdata : head entry (valid when !empty)
module nibble_fifo
  import ptosda_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [NIBBLE_W-1:0]       wdata,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [NIBBLE_W-1:0]       rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NIBBLE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ptosda_sched.sv
// Round-robin scheduler sharing one ptosda serial transmitter between NREQ
// nibble producers. Each producer owns a nibble_fifo; the FSM grants one
// requester, presents its head nibble on ser_data and waits for a rising
// edge of ser_ack before moving on. Up to BURST nibbles go to one requester
// before re-arbitration.
//   sclk      : clock, rising edge
//   rst       : asynchronous active-low reset
//   req_valid : per-requester push strobe
//   req_data  : nibble i at [4i+3:4i]
//   req_ready : FIFO i not full
//   ser_data  : nibble for ptosda.data
//   ser_valid : ser_data holds an unacknowledged nibble
//   ser_ack   : ptosda.ack level, edge-detected here
//   grant     : requester whose nibble is on ser_data
//   busy      : FSM not idle
module ptosda_sched
  import ptosda_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BURST = 2
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NIBBLE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NIBBLE_W-1:0]      ser_data,
  output logic                     ser_valid,
  input  logic                     ser_ack,
  output logic [1:0]               grant,
  output logic                     busy
);

  localparam int unsigned BW = $clog2(BURST + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] BurstMax = BW'(BURST);

  state_t              state_q;
  logic [1:0]          grant_q;
  logic [1:0]          last_grant_q;
  logic [BW-1:0]       burst_cnt_q;
  logic [NIBBLE_W-1:0] ser_data_q;
  logic                ser_valid_q;
  logic                ack_q;
  logic                ack_rise;

  logic [NREQ-1:0]     fifo_full;
  logic [NREQ-1:0]     fifo_empty;
  logic [NREQ-1:0]     fifo_pop;
  logic [CW-1:0]       fifo_count [NREQ];
  logic [NIBBLE_W-1:0] fifo_head  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    assign fifo_pop[i] = (state_q == LOAD) && (grant_q == 2'(i));

    nibble_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .sclk  (sclk),
      .rst   (rst),
      .push  (req_valid[i]),
      .wdata (req_data[NIBBLE_W*i +: NIBBLE_W]),
      .pop   (fifo_pop[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_count[i]),
      .rdata (fifo_head[i])
    );
  end

  // Zero-padded 4-entry views so a 2-bit index is always in range.
  logic [3:0]                pend4;
  logic [3:0]                more4;
  logic [3:0][NIBBLE_W-1:0]  head4;
  logic                      any_pend;

  always_comb begin
    pend4 = '0;
    more4 = '0;
    head4 = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend4[i] = !fifo_empty[i];
      more4[i] = (fifo_count[i] != '0);
      head4[i] = fifo_head[i];
    end
  end

  assign any_pend = |pend4;

  // Round-robin search starting one past the last served requester.
  logic [1:0] arb_idx;
  logic [1:0] cand;
  logic       arb_found;

  always_comb begin
    arb_idx   = last_grant_q;
    cand      = last_grant_q;
    arb_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = rr_next(cand, NREQ);
      if (!arb_found && pend4[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  // Only a fresh 0->1 transition counts; a level held high is ignored.
  assign ack_rise = ser_ack && !ack_q;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'(NREQ - 1);
      burst_cnt_q  <= '0;
      ser_data_q   <= '0;
      ser_valid_q  <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      ack_q <= ser_ack;
      case (state_q)
        IDLE: begin
          if (any_pend) state_q <= ARB;
        end
        ARB: begin
          grant_q     <= arb_idx;
          burst_cnt_q <= '0;
          state_q     <= LOAD;
        end
        LOAD: begin
          ser_data_q  <= head4[grant_q];
          ser_valid_q <= 1'b1;
          burst_cnt_q <= burst_cnt_q + BW'(1);
          state_q     <= WAIT;
        end
        WAIT: begin
          if (ack_rise) begin
            ser_valid_q  <= 1'b0;
            last_grant_q <= grant_q;
            if (more4[grant_q] && (burst_cnt_q < BurstMax)) begin
              state_q <= LOAD;
            end else if (any_pend) begin
              state_q <= ARB;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ~fifo_full;
  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
